// File: rtl/mux_pkg.sv
//------------------------------------------------------------------------------
// Module   : mux_pkg
// Brief    : Shared types, limits and width helper for the N:1 mux family.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int MUX_MAX_N = 16;

    // Never returns 0, so a pointer/select port always has at least one bit.
    function automatic int mux_sw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational circular-priority arbiter starting at ptr.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = mux_sw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx
);

    logic          w_found;
    logic [SW-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = SW'((int'(ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                w_found       = 1'b1;
                gnt[w_idx]    = 1'b1;
                gnt_idx       = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_nx1_rr.sv
//------------------------------------------------------------------------------
// Module   : mux_nx1_rr
// Brief    : N:1 valid/ready mux, fixed or round-robin select, registered out.
//            Optional macro MUX_CHAN_ID_EN adds the out_chan source-index port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = mux_sw(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    input  logic            rr_en,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
`ifdef MUX_CHAN_ID_EN
    output logic [SW-1:0]   out_chan,
`endif
    input  logic            out_ready
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]    r_state;
    logic [W-1:0]  r_data;
    logic [SW-1:0] r_ptr;

    mode_e         w_mode;
    logic [N-1:0]  w_fixed_gnt;
    logic [N-1:0]  w_rr_gnt;
    logic [N-1:0]  w_gnt;
    logic [SW-1:0] w_rr_idx;
    logic [W-1:0]  w_gnt_data;
    logic          w_load_en;
    logic          w_xfer;

    assign w_mode = mode_e'(rr_en);

    // A select beyond the last channel (non power-of-two N) grants nothing.
    always_comb begin
        w_fixed_gnt = '0;
        if (int'(sel) < N) begin
            w_fixed_gnt[sel] = in_valid[sel];
        end
    end

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx)
    );

    assign w_gnt = (w_mode == MODE_RR) ? w_rr_gnt : w_fixed_gnt;

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_gnt_data = in_data[i*W +: W];
            end
        end
    end

    // rst_n in the load enable keeps every in_ready low while reset is held.
    assign w_load_en = rst_n & ((r_state == ST_EMPTY) | out_ready);
    assign in_ready  = w_gnt & {N{w_load_en}};
    assign w_xfer    = |in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_load_en) begin
                if (w_xfer) begin
                    r_state <= ST_FULL;
                    r_data  <= w_gnt_data;
                end else begin
                    r_state <= ST_EMPTY;
                end
            end
            if (w_xfer && (w_mode == MODE_RR)) begin
                r_ptr <= (w_rr_idx == SW'(N - 1)) ? '0 : w_rr_idx + SW'(1);
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;

`ifdef MUX_CHAN_ID_EN
    logic [SW-1:0] w_gnt_idx;
    logic [SW-1:0] r_chan;

    assign w_gnt_idx = (w_mode == MODE_RR) ? w_rr_idx : sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chan <= '0;
        end else if (w_xfer) begin
            r_chan <= w_gnt_idx;
        end
    end

    assign out_chan = r_chan;
`endif

endmodule

`default_nettype wire

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
- Parametrised successor to the team's gate-level 2:1 mux.
- Selects one of N W-bit input channels onto a single registered output, with a valid/ready handshake on every channel and on the output.
- Two selection modes: fixed, where an external sel picks the channel, and round-robin, where channels are arbitrated fairly.
- Sits between multiple producers and one consumer in the datapath.

Parameters:
N, 4, number of input channels (2..16)
W, 8, data width per channel in bits (1..64)
SW, $clog2(N), select/pointer width (derived; not overridden)

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_data  input  N*W  channel i occupies bits [i*W +: W]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready; at most one bit high per cycle
sel  input  SW  channel select, used when rr_en=0
rr_en  input  1  0 = fixed mode (sel), 1 = round-robin mode
out_data  output  W  registered output data
out_valid  output  1  output holds valid data
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset values (async, while rst_n=0): out_valid=0, out_data=0, rr_ptr=0, in_ready=0.
- State machine, two states:
  - EMPTY (out_valid=0): output register is free.
  - FULL (out_valid=1): output register holds data.
- load_en = !out_valid | out_ready. The output register may load a new beat in the same cycle the old one drains, giving full throughput of 1 beat/cycle.
- Grant, combinational, one-hot or zero:
  - fixed mode: grant[sel] = in_valid[sel]; no other channel is granted.
  - RR mode: lowest index i, searched circularly from rr_ptr (rr_ptr, rr_ptr+1, ... mod N), with in_valid[i]=1.
- in_ready = grant & {N{load_en}}. Transfer on channel i occurs when in_valid[i] & in_ready[i].
- On transfer at edge k: out_data = channel i data and out_valid=1, both visible after edge k. Latency is exactly 1 cycle.
- load_en=1 with no grant: out_valid goes to 0 and out_data holds its old value.
- FULL & !out_ready: out_data and out_valid hold stable, and all in_ready are 0 (backpressure).
- rr_ptr advances only on a transfer in RR mode, to (i+1) mod N. Wrap-around from N-1 goes to 0.
- rr_ptr is unchanged in fixed mode. Switching rr_en takes effect on the next cycle's grant; rr_ptr is not reset by a mode change.
- sel >= N (only possible when N is not a power of 2): no grant.
- sel and rr_en may change every cycle. They affect only the grant, never data already held.
- Reset mid-operation discards the held beat. No transfer is reported for it.
- Input valid rules:
  - Producers must not drop in_valid before their transfer completes.
  - The block does not require this. A dropped request simply loses its grant.

Optional Feature:
Macro MUX_CHAN_ID_EN.
- Defined:
  - Adds output port out_chan [SW-1:0], registered alongside out_data. It holds the source channel index of the current beat.
  - Reset value 0; holds with out_data.
- Undefined: no out_chan port and no extra flops. All other behaviour is identical.

Decomposition:
- Shared package mux_pkg holds:
  - a typedef for the mode encoding: MODE_FIXED=0, MODE_RR=1;
  - a clog2-safe width function for SW;
  - a constant MUX_MAX_N=16.
- One sub-module, rr_arbiter (parameter N):
  - inputs: req[N], ptr[SW];
  - outputs: one-hot gnt[N], gnt_idx[SW];
  - purely combinational.
  - The top level holds rr_ptr, the output register and the FSM.

Test Plan:
Use N=4, W=8.
1. Reset mid-transfer: out_valid=1 with data 0x5A, then assert rst_n=0 for 2 cycles -> out_valid=0, out_data=0x00 and in_ready=0 during reset; first RR grant after release is channel 0.
2. Fixed mode: rr_en=0, sel=2, all valid, ch0..3 data 0x10,0x20,0x30,0x40, out_ready=1 -> in_ready=4'b0100 every cycle; out_data=0x30 each cycle from cycle 1.
3. Round-robin fairness: rr_en=1, all four valid continuously, out_ready=1 -> out_data sequence 0x10,0x20,0x30,0x40,0x10 (wrap); each channel granted once per 4 cycles.
4. Sparse RR: only ch1 and ch3 valid, rr_ptr=2 -> ch3 first, then ch1, then ch3; skipped channels never see in_ready.
5. Backpressure: out_ready=0 for 3 cycles while FULL with 0x20 -> out_data stays 0x20, in_ready=0, rr_ptr unchanged; out_ready=1 -> next beat loads in that same cycle.
6. MUX_CHAN_ID_EN defined, RR with all valid -> out_chan follows 0,1,2,3,0 aligned with out_data; sel=2 in fixed mode -> out_chan=2.
